// File: rtl/turn_sequencer_if.sv
// Handshake and status bundle between the dice front end / renderer (master)
// and the turn sequencer (slave).
interface turn_sequencer_if;
  logic       restart;
  logic       dice_valid;
  logic [2:0] dice_value;
  logic       dice_ready;
  logic       turn_done;
  logic [9:0] player1_pos_x;
  logic [9:0] player2_pos_x;
  logic       pos_valid;
  logic       active_player;
  logic       winner_valid;
  logic       winner_id;
  logic       timeout_flag;
  logic [7:0] turn_count;

  modport master (
    output restart, dice_valid, dice_value, turn_done,
    input  dice_ready, player1_pos_x, player2_pos_x, pos_valid,
           active_player, winner_valid, winner_id, timeout_flag, turn_count
  );

  modport slave (
    input  restart, dice_valid, dice_value, turn_done,
    output dice_ready, player1_pos_x, player2_pos_x, pos_valid,
           active_player, winner_valid, winner_id, timeout_flag, turn_count
  );
endinterface

// File: rtl/turn_sequencer.sv
// Two-player dice race flow controller: accepts rolls, moves the active player,
// waits for the renderer's turn_done (or a timeout), alternates turns, declares a winner.
module turn_sequencer #(
  parameter int START_X      = 40,
  parameter int STEP_PX      = 60,
  parameter int FINISH_X     = 580,
  parameter int TIMEOUT_CYC  = 50000000,
  parameter int EXTRA_ON_SIX = 1
) (
  input  logic             clk,
  input  logic             rst,
  turn_sequencer_if.slave  bus
);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DONE, WIN} state_t;

  state_t           r_state;
  logic [9:0]       r_p1_pos;
  logic [9:0]       r_p2_pos;
  logic             r_active;
  logic             r_pos_valid;
  logic             r_dice_ready;
  logic             r_winner_valid;
  logic             r_winner_id;
  logic             r_timeout;
  logic [7:0]       r_turns;
  logic [2:0]       r_roll;
  logic [TMR_W-1:0] r_timer;

  // Advance by pips*STEP_PX in 11 bits, then clamp to the finish line.
  function automatic logic [9:0] sat_pos(input logic [9:0] pos, input logic [2:0] pips);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(pips) * 11'(STEP_PX);
    return (sum > 11'(FINISH_X)) ? 10'(FINISH_X) : sum[9:0];
  endfunction

  logic       w_roll_ok;
  logic [9:0] w_cur_pos;
  logic [9:0] w_new_pos;
  logic       w_done_evt;
  logic       w_tmo;
  logic       w_at_finish;

  assign w_roll_ok   = bus.dice_valid && (bus.dice_value != 3'd0) && (bus.dice_value != 3'd7);
  assign w_cur_pos   = r_active ? r_p2_pos : r_p1_pos;
  assign w_new_pos   = sat_pos(w_cur_pos, bus.dice_value);
  // turn_done in the pos_valid cycle belongs to the previous animation, so it is masked
  assign w_done_evt  = bus.turn_done && !r_pos_valid;
  assign w_tmo       = (r_timer == TMR_LAST);
  assign w_at_finish = (w_cur_pos == 10'(FINISH_X));

  always_ff @(posedge clk) begin
    if (rst || bus.restart) begin
      r_state        <= IDLE;
      r_p1_pos       <= 10'(START_X);
      r_p2_pos       <= 10'(START_X);
      r_active       <= 1'b0;
      r_pos_valid    <= 1'b0;
      r_dice_ready   <= 1'b1;
      r_winner_valid <= 1'b0;
      r_winner_id    <= 1'b0;
      r_timeout      <= 1'b0;
      r_turns        <= 8'd0;
      r_roll         <= 3'd0;
      r_timer        <= '0;
    end else begin
      r_pos_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_roll_ok) begin
            if (r_active) r_p2_pos <= w_new_pos;
            else          r_p1_pos <= w_new_pos;
            r_pos_valid  <= 1'b1;
            r_roll       <= bus.dice_value;
            r_timer      <= '0;
            r_dice_ready <= 1'b0;
            r_state      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          r_timer <= r_timer + 1'b1;
          if (w_done_evt || w_tmo) begin
            if (!w_done_evt) r_timeout <= 1'b1;
            if (r_turns != 8'hFF) r_turns <= r_turns + 8'd1;
            if (w_at_finish) begin
              r_state        <= WIN;
              r_winner_valid <= 1'b1;
              r_winner_id    <= r_active;
            end else begin
              r_state      <= IDLE;
              r_dice_ready <= 1'b1;
              if (!(r_roll == 3'd6 && EXTRA_ON_SIX != 0)) r_active <= ~r_active;
            end
          end
        end
        WIN: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.dice_ready    = r_dice_ready;
  assign bus.player1_pos_x = r_p1_pos;
  assign bus.player2_pos_x = r_p2_pos;
  assign bus.pos_valid     = r_pos_valid;
  assign bus.active_player = r_active;
  assign bus.winner_valid  = r_winner_valid;
  assign bus.winner_id     = r_winner_id;
  assign bus.timeout_flag  = r_timeout;
  assign bus.turn_count    = r_turns;
endmodule
